// File: rtl/sseg_scan_capture_pkg.sv
// Shared definitions for the seven-segment scan capture path.
// Holds the active-low {a,b,c,d,e,f,g} glyph patterns for 0..F (the same
// constants the hex-to-segment encoder uses), the blank pattern, the capture
// FSM state type and small helpers for decoding the anode select.
package sseg_scan_capture_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Exactly one anode pulled low.
    function automatic logic sel_valid(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) ||
               (an == 4'b1011) || (an == 4'b0111);
    endfunction

    // Digit index of the low anode; only meaningful when sel_valid().
    function automatic logic [1:0] sel_index(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sseg_to_hex_decode.sv
// Combinational seven-segment to hex decoder.
// Ports:
//   i_pattern  [6:0] active-low {a,b,c,d,e,f,g}
//   o_hex      [3:0] decoded nibble, 0 when the pattern is not a glyph
//   o_invalid        pattern is not one of the 16 glyphs (blank included)
module sseg_to_hex_decode
    import sseg_scan_capture_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_hex,
    output logic       o_invalid
);

    always_comb begin
        o_hex     = 4'h0;
        o_invalid = 1'b0;
        case (i_pattern)
            SEG_0:   o_hex = 4'h0;
            SEG_1:   o_hex = 4'h1;
            SEG_2:   o_hex = 4'h2;
            SEG_3:   o_hex = 4'h3;
            SEG_4:   o_hex = 4'h4;
            SEG_5:   o_hex = 4'h5;
            SEG_6:   o_hex = 4'h6;
            SEG_7:   o_hex = 4'h7;
            SEG_8:   o_hex = 4'h8;
            SEG_9:   o_hex = 4'h9;
            SEG_A:   o_hex = 4'hA;
            SEG_B:   o_hex = 4'hB;
            SEG_C:   o_hex = 4'hC;
            SEG_D:   o_hex = 4'hD;
            SEG_E:   o_hex = 4'hE;
            SEG_F:   o_hex = 4'hF;
            default: o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// Receive side of the four-digit multiplexed seven-segment interface.
// Synchronizes the anode/segment lines, waits for each dwell to be stable,
// decodes the digit and assembles a complete four-digit frame.
// Ports:
//   clk_amisha          system clock
//   reset_amisha        asynchronous active-low reset
//   an_amisha   [3:0]   anode enables, active-low one-hot
//   sseg_amisha [7:0]   segment lines, active-low, [7]=dp, [6:0]={a..g}
//   hex_amisha  [15:0]  last complete frame, digit i in [4i+3:4i]
//   dp_out_amisha [3:0] raw dp bit per digit
//   err_amisha  [3:0]   per digit: pattern not a glyph
//   frame_valid_amisha  one-cycle pulse when the outputs are updated
//
// state  | meaning
// IDLE   | no valid anode select on the lines
// SETTLE | valid select, counting identical samples toward capture
// HOLD   | current dwell already captured, waiting for a change
module sseg_scan_capture
    import sseg_scan_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk_amisha,
    input  logic        reset_amisha,
    input  logic [3:0]  an_amisha,
    input  logic [7:0]  sseg_amisha,
    output logic [15:0] hex_amisha,
    output logic [3:0]  dp_out_amisha,
    output logic [3:0]  err_amisha,
    output logic        frame_valid_amisha
);

    localparam logic [7:0] CNT_TC = 8'(STABLE_CYCLES);

    logic [11:0] r_sync [SYNC_STAGES];
    logic [11:0] r_prev;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        w_capture;

    logic [15:0] r_sh_hex;
    logic [3:0]  r_sh_dp;
    logic [3:0]  r_sh_err;
    logic [3:0]  r_seen;

    logic [11:0] w_smp;
    logic [3:0]  w_an_s;
    logic [7:0]  w_sseg_s;
    logic        w_sel_ok;
    logic        w_changed;
    logic [1:0]  w_idx;
    logic [3:0]  w_digit_bit;
    logic        w_complete;
    logic [3:0]  w_dec_hex;
    logic        w_dec_inv;
    logic [15:0] w_sh_hex_nxt;
    logic [3:0]  w_sh_dp_nxt;
    logic [3:0]  w_sh_err_nxt;

    // Anode and segment lines share one synchronizer chain so a digit switch
    // never shows up as a mixed sample. Reset to all-ones (nothing selected).
    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
            r_prev <= '1;
        end else begin
            r_sync[0] <= {an_amisha, sseg_amisha};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_smp       = r_sync[SYNC_STAGES-1];
    assign w_an_s      = w_smp[11:8];
    assign w_sseg_s    = w_smp[7:0];
    assign w_sel_ok    = sel_valid(w_an_s);
    assign w_changed   = (w_smp != r_prev);
    assign w_idx       = sel_index(w_an_s);
    assign w_digit_bit = 4'b0001 << w_idx;
    assign w_complete  = ((r_seen | w_digit_bit) == 4'b1111);

    sseg_to_hex_decode u_decode (
        .i_pattern (w_sseg_s[6:0]),
        .o_hex     (w_dec_hex),
        .o_invalid (w_dec_inv)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_ok) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = 8'd1;
                end
            end
            SETTLE: begin
                if (!w_sel_ok) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (w_changed) begin
                    w_cnt_nxt = 8'd1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    // Capture on the edge where the count of identical
                    // samples reaches the threshold.
                    if (r_cnt + 8'd1 == CNT_TC) begin
                        w_capture   = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!w_sel_ok) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (w_changed) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Shadow contents including the digit being captured this cycle, so a
    // completing capture commits the new digit on the same edge.
    always_comb begin
        w_sh_hex_nxt = r_sh_hex;
        w_sh_dp_nxt  = r_sh_dp;
        w_sh_err_nxt = r_sh_err;
        w_sh_hex_nxt[{w_idx, 2'b00} +: 4] = w_dec_inv ? 4'h0 : w_dec_hex;
        w_sh_dp_nxt[w_idx]  = w_sseg_s[7];
        w_sh_err_nxt[w_idx] = w_dec_inv;
    end

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            r_state            <= IDLE;
            r_cnt              <= 8'd0;
            r_sh_hex           <= 16'h0;
            r_sh_dp            <= 4'h0;
            r_sh_err           <= 4'h0;
            r_seen             <= 4'h0;
            hex_amisha         <= 16'h0;
            dp_out_amisha      <= 4'h0;
            err_amisha         <= 4'h0;
            frame_valid_amisha <= 1'b0;
        end else begin
            r_state            <= w_state_nxt;
            r_cnt              <= w_cnt_nxt;
            frame_valid_amisha <= 1'b0;
            if (w_capture) begin
                r_sh_hex <= w_sh_hex_nxt;
                r_sh_dp  <= w_sh_dp_nxt;
                r_sh_err <= w_sh_err_nxt;
                if (w_complete) begin
                    hex_amisha         <= w_sh_hex_nxt;
                    dp_out_amisha      <= w_sh_dp_nxt;
                    err_amisha         <= w_sh_err_nxt;
                    frame_valid_amisha <= 1'b1;
                    r_seen             <= 4'h0;
                end else begin
                    r_seen <= r_seen | w_digit_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_capture.sv
module tb_sseg_scan_capture;

    localparam int S  = 16;
    localparam int SY = 2;

    // Glyph table written out independently: index = hex value.
    localparam logic [6:0] TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  an = 4'hF;
    logic [7:0]  sseg = 8'hFF;
    logic [15:0] hex;
    logic [3:0]  dp_out;
    logic [3:0]  err;
    logic        fv;

    int total = 0;
    int bad   = 0;
    int n_fv  = 0;

    always #5 clk = ~clk;

    sseg_scan_capture #(.STABLE_CYCLES(S), .SYNC_STAGES(SY)) dut (
        .clk_amisha         (clk),
        .reset_amisha       (rst_n),
        .an_amisha          (an),
        .sseg_amisha        (sseg),
        .hex_amisha         (hex),
        .dp_out_amisha      (dp_out),
        .err_amisha         (err),
        .frame_valid_amisha (fv)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A digit is captured when the synchronized sample (the pin value SY
    // clocks earlier) has been identical for exactly S samples in a row and
    // selects exactly one digit.
    logic [11:0] m_pipe [SY];
    logic [11:0] m_last;
    logic [11:0] m_s;
    int          m_run;
    logic [15:0] m_sh_hex, e_hex;
    logic [3:0]  m_sh_dp, m_sh_err, m_seen, e_dp, e_err;
    logic        e_fv;

    function automatic int one_low_idx(input logic [3:0] a);
        int z = 0;
        int idx = -1;
        for (int i = 0; i < 4; i++) if (!a[i]) begin z++; idx = i; end
        return (z == 1) ? idx : -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SY; i++) m_pipe[i] = 12'hFFF;
            m_last = 12'hFFF; m_run = 0;
            m_sh_hex = 0; m_sh_dp = 0; m_sh_err = 0; m_seen = 0;
            e_hex = 0; e_dp = 0; e_err = 0; e_fv = 0;
        end else begin
            int   d;
            logic found;
            logic [3:0] hv;
            m_s = m_pipe[SY-1];
            for (int i = SY - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = {an, sseg};
            e_fv = 1'b0;
            if (m_s == m_last) begin
                if (m_run < 100000) m_run++;
            end else m_run = 1;
            m_last = m_s;
            d = one_low_idx(m_s[11:8]);
            if (d >= 0 && m_run == S) begin
                found = 1'b0; hv = 4'h0;
                for (int k = 0; k < 16; k++)
                    if (m_s[6:0] == TAB[k]) begin found = 1'b1; hv = 4'(k); end
                m_sh_hex[d*4 +: 4] = hv;
                m_sh_dp[d]  = m_s[7];
                m_sh_err[d] = ~found;
                m_seen[d]   = 1'b1;
                if (m_seen == 4'hF) begin
                    e_hex = m_sh_hex; e_dp = m_sh_dp; e_err = m_sh_err;
                    e_fv = 1'b1; m_seen = 4'h0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("cyc_hex", hex, e_hex);
            chk("cyc_dp", {12'h0, dp_out}, {12'h0, e_dp});
            chk("cyc_err", {12'h0, err}, {12'h0, e_err});
            chk("cyc_fv", {15'h0, fv}, {15'h0, e_fv});
            if (fv === 1'b1) n_fv++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
        an = a; sseg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3, input int n);
        dwell(4'b1110, d0, n);
        dwell(4'b1101, d1, n);
        dwell(4'b1011, d2, n);
        dwell(4'b0111, d3, n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; an = 4'hF; sseg = 8'hFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int p0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_hex", hex, 16'h0);
        chk("rst_dp", {12'h0, dp_out}, 16'h0);
        chk("rst_err", {12'h0, err}, 16'h0);
        chk("rst_fv", {15'h0, fv}, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic scan 0,1,2,3 with dp lines high.
        p0 = n_fv;
        scan(8'h81, 8'hCF, 8'h92, 8'h86, 40);
        chk("t1_pulses", 16'(n_fv - p0), 16'd1);
        chk("t1_hex", hex, 16'h3210);
        chk("t1_model_hex", e_hex, 16'h3210);
        chk("t1_dp", {12'h0, dp_out}, 16'h000F);
        chk("t1_err", {12'h0, err}, 16'h0);

        // Digit 0 one sample short; the others are captured.
        p0 = n_fv;
        dwell(4'b1110, 8'h84, S - 1);
        dwell(4'b1101, 8'hCF, 40);
        dwell(4'b1011, 8'h92, 40);
        dwell(4'b0111, 8'h86, 40);
        chk("t2_no_pulse", 16'(n_fv - p0), 16'd0);
        chk("t2_hex_hold", hex, 16'h3210);
        // Next scan: commit happens on digit 0 with the earlier 1..3.
        scan(8'hCC, 8'hA4, 8'hA0, 8'h8F, 40);
        chk("t2_pulses", 16'(n_fv - p0), 16'd1);
        chk("t2_hex", hex, 16'h3214);
        chk("t2_model_hex", e_hex, 16'h3214);
        do_reset();

        // Blank digit 2.
        p0 = n_fv;
        scan(8'hCC, 8'hA4, 8'hFF, 8'hA0, 40);
        chk("t3_pulses", 16'(n_fv - p0), 16'd1);
        chk("t3_err", {12'h0, err}, 16'h0004);
        chk("t3_hex", hex, 16'h6054);
        chk("t3_dp", {12'h0, dp_out}, 16'h000F);

        // Digit 1 shows A then B before the frame completes.
        p0 = n_fv;
        dwell(4'b1101, 8'h88, 40);
        dwell(4'b1101, 8'hE0, 40);
        dwell(4'b1110, 8'h81, 40);
        dwell(4'b1011, 8'h92, 40);
        dwell(4'b0111, 8'h86, 40);
        chk("t5_pulses", 16'(n_fv - p0), 16'd1);
        chk("t5_hex", hex, 16'h32B0);

        // Invalid selects: no captures, outputs hold.
        p0 = n_fv;
        dwell(4'b1100, 8'h81, 50);
        dwell(4'b1111, 8'h81, 50);
        chk("t4_pulses", 16'(n_fv - p0), 16'd0);
        chk("t4_hex", hex, 16'h32B0);

        // Three digits then async reset mid-frame.
        p0 = n_fv;
        dwell(4'b1110, 8'h81, 40);
        dwell(4'b1101, 8'hCF, 40);
        dwell(4'b1011, 8'h92, 40);
        chk("t6_no_pulse", 16'(n_fv - p0), 16'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_hex", hex, 16'h0);
        chk("t6_rst_dp", {12'h0, dp_out}, 16'h0);
        chk("t6_rst_err", {12'h0, err}, 16'h0);
        an = 4'hF; sseg = 8'hFF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        p0 = n_fv;
        // Only digit 3 alone must not commit (seen was cleared by reset).
        dwell(4'b0111, 8'h88, 40);
        chk("t6_no_commit", 16'(n_fv - p0), 16'd0);
        scan(8'h0F, 8'h00, 8'h04, 8'h88, 40);
        chk("t6_pulses", 16'(n_fv - p0), 16'd1);
        chk("t6_hex", hex, 16'hA987);
        chk("t6_dp", {12'h0, dp_out}, 16'h0008);

        // Randomized dwells against the model.
        for (int n = 0; n < 250; n++) begin
            logic [3:0] a;
            logic [7:0] s;
            int len;
            if ($urandom_range(0, 9) == 0) a = 4'($urandom_range(0, 15));
            else a = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) s = 8'($urandom_range(0, 255));
            else s = {1'($urandom_range(0, 1)), TAB[$urandom_range(0, 15)]};
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 4);
                1:       len = $urandom_range(S - 2, S + 2);
                default: len = $urandom_range(S + 3, 40);
            endcase
            dwell(a, s, len);
        end
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sseg_scan_capture.md
Name: sseg_scan_capture

Overview:
- Receive side of the four-digit multiplexed seven-segment interface. The display multiplexer drives the anode and segment lines; this block listens to the same lines.
- Samples the anode/segment lines, waits until each dwell is stable, decodes the segment pattern back to a hex nibble plus decimal point, and assembles one complete four-digit frame.
- Used as the self-check partner of the hex-to-segment display path on the test top, and as a pin-level monitor on hardware.

Parameters:
- STABLE_CYCLES, 16, consecutive identical synchronized samples required before a dwell is captured (range 2..255).
- SYNC_STAGES, 2, flip-flop stages on an/sseg inputs before any logic (range 2..3).

Ports:
- clk_amisha  in  1  system clock.
- reset_amisha  in  1  asynchronous, active-low reset.
- an_amisha  in  4  anode enables, active-low, one-hot low; an[i]=0 selects digit i.
- sseg_amisha  in  8  segment lines, active-low; [7]=dp, [6:0]={a,b,c,d,e,f,g}.
- hex_amisha  out  16  last complete frame, digit i in [4i+3:4i].
- dp_out_amisha  out  4  raw sseg[7] captured per digit.
- err_amisha  out  4  per digit: pattern not in the decode table (includes blank 7'b1111111).
- frame_valid_amisha  out  1  one-cycle pulse when hex/dp/err are updated.

Behaviour:
- Reset (async assert, sync release): hex=0, dp_out=0, err=0, frame_valid=0, seen mask=0, shadow regs=0, stable counter=0, state=IDLE.
- Inputs pass through SYNC_STAGES flops; all logic below uses the synchronized sample (an_s, sseg_s) and its one-cycle-delayed copy (prev).
- Valid select: an_s has exactly one zero. 4'b1111, or more than one zero, is invalid.
- FSM:
  - IDLE: when the select is valid, go to SETTLE with cnt=1.
  - SETTLE: if the select is invalid, go to IDLE with cnt=0. If {an_s,sseg_s} != prev, set cnt=1 and stay. Otherwise cnt++. When cnt reaches STABLE_CYCLES, perform a capture on that edge and go to HOLD.
  - HOLD: no further capture. Any change of {an_s,sseg_s} goes to SETTLE with cnt=1. An invalid select goes to IDLE.
- A long dwell therefore yields exactly one capture. Minimum latency from pin change to capture = SYNC_STAGES + STABLE_CYCLES - 1 clocks.
- Capture of digit i:
  - Write shadow_hex[i] = decode(sseg_s[6:0]), shadow_dp[i] = sseg_s[7], shadow_err[i] = (pattern invalid).
  - Set seen[i].
  - Invalid pattern: shadow_hex[i] = 4'h0.
- Frame commit: if seen | (1<<i) == 4'b1111 on the capture edge, then on that same edge:
  - load hex/dp_out/err from the shadow including the new digit;
  - frame_valid=1 for exactly that one cycle;
  - clear seen to 0.
- Re-capture of a digit already in seen before the frame completes overwrites its shadow; seen is unchanged. Scan order is irrelevant.
- Segment change within one anode dwell (e.g. counter update) restarts the stability count, then captures the new value.
- Reset mid-frame discards seen and the shadow; outputs return to their reset values.
- Outputs hold between frames; no consumer handshake (pulse semantics only).
- Decode table, active-low {a..g}:

  | Hex | Pattern | Hex | Pattern |
  |-----|---------|-----|---------|
  | 0 | 0000001 | 8 | 0000000 |
  | 1 | 1001111 | 9 | 0000100 |
  | 2 | 0010010 | A | 0001000 |
  | 3 | 0000110 | B | 1100000 |
  | 4 | 1001100 | C | 0110001 |
  | 5 | 0100100 | D | 1000010 |
  | 6 | 0100000 | E | 0110000 |
  | 7 | 0001111 | F | 0111000 |

  Any other pattern is invalid.

Decomposition:
- Shared package:
  - the 16 segment pattern constants (shared with the encoder so both ends stay identical);
  - FSM state encoding IDLE/SETTLE/HOLD;
  - a BLANK = 7'b1111111 constant.
- One combinational sub-module, sseg_to_hex_decode: input 7-bit pattern, outputs 4-bit hex and a 1-bit invalid flag.
- Synchronizer, FSM, counter, shadow and frame logic stay in the top.

Test Plan:
- Scan 4 digits, an=1110/1101/1011/0111, sseg=8'h81/8'hCF/8'h92/8'h86 (0,1,2,3 with sseg[7]=1), 40 clocks each → one frame_valid pulse; hex=16'h3210, dp_out=4'b1111, err=0.
- Dwell digit 0 for only STABLE_CYCLES-1 synced clocks, then the other three digits → no capture of digit 0, no frame_valid. Next full scan → frame commits.
- Digit 2 blank (sseg=8'hFF) in a scan with 4,5,6 on the others → frame_valid; err=4'b0100, hex[11:8]=0.
- an=1100 (two low) or 1111 held for 50 clocks → no captures, seen stays 0, outputs unchanged.
- Drive digit 1 with 'A' then 'B' before completing the frame → committed hex[7:4]=4'hB; exactly one frame_valid.
- Assert reset_amisha=0 asynchronously after 3 digits are captured → outputs and seen clear immediately. Full scan after release → one clean frame_valid.
